lut4_frame_config_loader: RTL and testbench
===========================================

// Module: lut4_frame_config_loader
// PURPOSE
//  Configuration-side writer for frame-configured tiles such as the LUT4AB slice. Accepts a word stream
//  (sync word, then header/data pairs), drives FrameData plus a one-hot FrameStrobe to latch one frame
//  column. Sits between the bitstream source and the tile frame latches.
// PARAMETERS
//  FrameBitsPerRow  32            width of FrameData and of every stream word
//  MaxFramesPerCol  20            number of FrameStrobe lines (frame indices 0..MaxFramesPerCol-1)
//  SYNC_WORD        32'hFAB0_FAB1 word that moves UNSYNC -> HDR
// PORTS
//  UserCLK      in   1                 clock; all logic on posedge
//  SR           in   1                 synchronous active-high reset
//  s_data       in   FrameBitsPerRow   stream word
//  s_valid      in   1                 s_data valid
//  s_ready      out  1                 loader accepts word; transfer = s_valid & s_ready
//  FrameData    out  FrameBitsPerRow   frame data to tile rows
//  FrameStrobe  out  MaxFramesPerCol   one-hot frame latch strobe
//  synced       out  1                 high in every state except UNSYNC
//  err          out  1                 sticky error flag; cleared only by SR
// BEHAVIOUR
//  - Reset (SR=1 at edge): state=UNSYNC, FrameData=0, FrameStrobe=0, s_ready=0 for that cycle, err=0.
//    SR wins over any simultaneous transfer; a frame in flight is dropped with no strobe.
//  - States: UNSYNC, HDR, DATA, SETUP, STROBE. s_ready=1 in UNSYNC/HDR/DATA, 0 in SETUP/STROBE.
//  - UNSYNC: words != SYNC_WORD discarded silently; SYNC_WORD -> HDR.
//  - HDR: header opcode = s_data[31:24], index = s_data[7:0].
//    0x01 WRITE -> latch index, go DATA. 0x02 DESYNC -> UNSYNC. 0x00 NOP -> stay HDR.
//    Any other opcode -> err=1, go UNSYNC (resync required).
//  - DATA: transfer in cycle N registers s_data into FrameData at edge N+1, state -> SETUP.
//  - SETUP: one cycle, FrameData stable, FrameStrobe=0 -> STROBE.
//  - STROBE: FrameStrobe[index]=1 for exactly one cycle when index < MaxFramesPerCol; otherwise
//    FrameStrobe stays 0 and err=1. Next state HDR.
//  - Latency: data accepted at cycle N -> strobe high during cycle N+2. FrameData is held until the
//    next DATA transfer, so it is stable >=1 cycle before, during and after the strobe.
//  - Throughput: one frame per 4 cycles (HDR, DATA, SETUP, STROBE) with s_valid held high.
//  - FrameStrobe is never multi-hot; it is registered, with no combinational path from inputs.
//  - s_valid may drop between words; state is held while waiting, with no timeout.
//  - err stays set through resync; loading continues after an error.
// TESTING
//  1 SR=1 then stream {32'h1234_5678, SYNC_WORD, 32'h0100_0003, 32'hDEAD_BEEF}
//    -> no action before sync; FrameData=DEADBEEF; FrameStrobe=20'h00008 for 1 cycle, 2 cycles after
//    the data transfer; err=0.
//  2 Back-to-back WRITE index 0 and 19 with s_valid always 1 -> strobes 20'h00001 then 20'h80000,
//    4 cycles apart; s_ready low in SETUP/STROBE.
//  3 WRITE index 20 with data 32'h0000_00FF -> FrameData=FF, FrameStrobe stays 0, err=1.
//    A following valid WRITE still strobes.
//  4 Header 32'h7F00_0000 -> err=1, synced=0; next header ignored until SYNC_WORD is resent.
//  5 SR asserted in the SETUP cycle -> no strobe, FrameData=0, synced=0, err=0.
//  6 DESYNC 32'h0200_0000, then a WRITE header without sync -> synced=0 and no strobe.

Source files
------------

// File: rtl/lut4_frame_config_loader.sv
// Frame configuration loader: syncs onto a word stream and writes one frame column per
// WRITE header/data pair via FrameData and a registered one-hot FrameStrobe.
module lut4_frame_config_loader #(
    parameter int unsigned                FrameBitsPerRow = 32,
    parameter int unsigned                MaxFramesPerCol = 20,
    parameter logic [FrameBitsPerRow-1:0] SYNC_WORD       = 32'hFAB0_FAB1
) (
    input  logic                       UserCLK,
    input  logic                       SR,
    input  logic [FrameBitsPerRow-1:0] s_data,
    input  logic                       s_valid,
    output logic                       s_ready,
    output logic [FrameBitsPerRow-1:0] FrameData,
    output logic [MaxFramesPerCol-1:0] FrameStrobe,
    output logic                       synced,
    output logic                       err
);

    typedef enum logic [2:0] {
        StUnsync,
        StHdr,
        StData,
        StSetup,
        StStrobe
    } state_e;

    localparam logic [7:0] OpNop    = 8'h00;
    localparam logic [7:0] OpWrite  = 8'h01;
    localparam logic [7:0] OpDesync = 8'h02;

    state_e                     state_q;
    logic [FrameBitsPerRow-1:0] data_q;
    logic [MaxFramesPerCol-1:0] strobe_q;
    logic [7:0]                 idx_q;
    logic                       ready_q;
    logic                       synced_q;
    logic                       err_q;

    logic                       xfer;
    logic [7:0]                 opcode;
    logic [MaxFramesPerCol-1:0] idx_onehot;
    logic                       idx_ok;

    always_comb begin
        xfer       = s_valid & ready_q;
        opcode     = s_data[31:24];
        idx_ok     = (32'(idx_q) < MaxFramesPerCol);
        idx_onehot = '0;
        for (int unsigned i = 0; i < MaxFramesPerCol; i++) begin
            idx_onehot[i] = (32'(idx_q) == i);
        end
    end

    always_ff @(posedge UserCLK) begin
        if (SR) begin
            state_q  <= StUnsync;
            data_q   <= '0;
            strobe_q <= '0;
            idx_q    <= '0;
            ready_q  <= 1'b0;
            synced_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            strobe_q <= '0;
            ready_q  <= 1'b1;
            unique case (state_q)
                StUnsync: begin
                    synced_q <= 1'b0;
                    if (xfer && s_data == SYNC_WORD) begin
                        state_q  <= StHdr;
                        synced_q <= 1'b1;
                    end
                end
                StHdr: begin
                    synced_q <= 1'b1;
                    if (xfer) begin
                        unique case (opcode)
                            OpWrite: begin
                                idx_q   <= s_data[7:0];
                                state_q <= StData;
                            end
                            OpNop: state_q <= StHdr;
                            OpDesync: begin
                                state_q  <= StUnsync;
                                synced_q <= 1'b0;
                            end
                            default: begin
                                err_q    <= 1'b1;
                                state_q  <= StUnsync;
                                synced_q <= 1'b0;
                            end
                        endcase
                    end
                end
                StData: begin
                    synced_q <= 1'b1;
                    if (xfer) begin
                        data_q  <= s_data;
                        state_q <= StSetup;
                        ready_q <= 1'b0;
                    end
                end
                StSetup: begin
                    // Strobe is registered here so it is high exactly during the STROBE cycle.
                    synced_q <= 1'b1;
                    ready_q  <= 1'b0;
                    state_q  <= StStrobe;
                    if (idx_ok) begin
                        strobe_q <= idx_onehot;
                    end else begin
                        err_q <= 1'b1;
                    end
                end
                StStrobe: begin
                    synced_q <= 1'b1;
                    state_q  <= StHdr;
                end
                default: begin
                    state_q  <= StUnsync;
                    synced_q <= 1'b0;
                end
            endcase
        end
    end

    assign s_ready     = ready_q;
    assign FrameData   = data_q;
    assign FrameStrobe = strobe_q;
    assign synced      = synced_q;
    assign err         = err_q;

endmodule

// File: tb/tb_lut4_frame_config_loader.sv
// Scoreboard bench: stimulus pushes expected strobes, a negedge monitor pops and compares them.
module tb_lut4_frame_config_loader;

    localparam logic [31:0] SYNC = 32'hFAB0_FAB1;

    logic        clk     = 1'b0;
    logic        sr      = 1'b1;
    logic [31:0] s_data  = '0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [31:0] frame_data;
    logic [19:0] frame_strobe;
    logic        synced;
    logic        err;

    lut4_frame_config_loader #(
        .FrameBitsPerRow(32),
        .MaxFramesPerCol(20),
        .SYNC_WORD      (SYNC)
    ) dut (
        .UserCLK    (clk),
        .SR         (sr),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .FrameData  (frame_data),
        .FrameStrobe(frame_strobe),
        .synced     (synced),
        .err        (err)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int unsigned cyc;
        logic [19:0] strobe;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // Holds s_valid high until the word is accepted; returns the cycle of the transfer.
    task automatic send(input logic [31:0] w, output int unsigned xc);
        bit done;
        done    = 1'b0;
        xc      = 0;
        s_data  = w;
        s_valid = 1'b1;
        for (int k = 0; k < 32 && !done; k++) begin
            @(negedge clk);
            if (s_ready === 1'b1) begin
                done = 1'b1;
                xc   = cyc;
            end
            @(posedge clk);
            #1;
        end
        if (!done) chk("send_timeout", 64'd1, 64'd0);
    endtask

    task automatic idle(input int n);
        s_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic write_frame(input logic [7:0] idx, input logic [31:0] data, input bit exp,
                               output int unsigned xc);
        int unsigned hc;
        logic [19:0] one;
        exp_t        e;
        one = 20'd1;
        send({8'h01, 16'h0000, idx}, hc);
        send(data, xc);
        if (exp) begin
            e.cyc    = xc + 2;
            e.strobe = one << idx;
            e.data   = data;
            sb.push_back(e);
        end
    endtask

    always @(negedge clk) begin
        if (!$isunknown(frame_strobe) && frame_strobe != '0) begin
            chk("strobe_onehot", 64'($onehot(frame_strobe)), 64'd1);
            chk("ready_in_strobe", 64'(s_ready), 64'd0);
            if (sb.size() == 0) begin
                chk("unexpected_strobe", 64'(frame_strobe), 64'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("strobe_value", 64'(frame_strobe), 64'(mon_e.strobe));
                chk("strobe_data", 64'(frame_data), 64'(mon_e.data));
                chk("strobe_cycle", 64'(cyc), 64'(mon_e.cyc));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, want finished");
        $fatal(1);
    end

    initial begin
        int unsigned xa, xb, xd;

        // Reset and sync, then a single frame to index 3.
        sr = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        sr = 1'b0;
        chk("rst_framedata", 64'(frame_data), 64'd0);
        chk("rst_strobe", 64'(frame_strobe), 64'd0);
        chk("rst_synced", 64'(synced), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_ready", 64'(s_ready), 64'd0);
        send(32'h1234_5678, xd);
        chk("junk_synced", 64'(synced), 64'd0);
        send(SYNC, xd);
        chk("sync_synced", 64'(synced), 64'd1);
        write_frame(8'd3, 32'hDEAD_BEEF, 1'b1, xd);
        idle(4);
        chk("t1_framedata", 64'(frame_data), 64'hDEAD_BEEF);
        chk("t1_err", 64'(err), 64'd0);

        // Back-to-back frames at the index boundaries.
        write_frame(8'd0, 32'h0000_0A00, 1'b1, xa);
        write_frame(8'd19, 32'h1900_0019, 1'b1, xb);
        chk("t2_spacing", 64'(xb - xa), 64'd4);
        idle(4);
        chk("t2_framedata_held", 64'(frame_data), 64'h1900_0019);

        // Out-of-range index: data lands, no strobe, sticky error; later frames still work.
        write_frame(8'd20, 32'h0000_00FF, 1'b0, xd);
        idle(4);
        chk("t3_framedata", 64'(frame_data), 64'h0000_00FF);
        chk("t3_err", 64'(err), 64'd1);
        write_frame(8'd5, 32'hA5A5_5A5A, 1'b1, xd);
        idle(4);
        chk("t3_err_sticky", 64'(err), 64'd1);

        // Illegal opcode drops sync; headers are ignored until SYNC_WORD returns.
        send(32'h7F00_0000, xd);
        chk("t4_err", 64'(err), 64'd1);
        chk("t4_synced", 64'(synced), 64'd0);
        send(32'h0100_0001, xd);
        send(32'h0BAD_F00D, xd);
        idle(4);
        chk("t4_still_unsynced", 64'(synced), 64'd0);
        chk("t4_framedata", 64'(frame_data), 64'hA5A5_5A5A);
        send(SYNC, xd);
        chk("t4_resynced", 64'(synced), 64'd1);
        write_frame(8'd7, 32'h7777_0007, 1'b1, xd);
        idle(4);

        // Reset during SETUP drops the frame.
        write_frame(8'd2, 32'h2222_2222, 1'b0, xd);
        sr = 1'b1;
        @(posedge clk);
        #1;
        sr = 1'b0;
        chk("t5_framedata", 64'(frame_data), 64'd0);
        chk("t5_synced", 64'(synced), 64'd0);
        chk("t5_err", 64'(err), 64'd0);
        chk("t5_strobe", 64'(frame_strobe), 64'd0);
        idle(4);

        // DESYNC, then a WRITE without resync does nothing.
        send(SYNC, xd);
        send(32'h0200_0000, xd);
        chk("t6_synced", 64'(synced), 64'd0);
        send(32'h0100_0004, xd);
        send(32'h1111_2222, xd);
        idle(6);
        chk("t6_still_unsynced", 64'(synced), 64'd0);
        chk("t6_framedata", 64'(frame_data), 64'd0);
        chk("t6_err", 64'(err), 64'd0);

        chk("pending_strobes", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
